// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transceiver.
package i2s_pkg;

  localparam int unsigned I2S_DATA_W = 32;

  // Default Tx FIFO geometry and reset-time threshold values.
  localparam int unsigned I2S_TXFIFO_DEPTH  = 8;
  localparam int unsigned I2S_TXFIFO_AF_DEF = I2S_TXFIFO_DEPTH - 2;
  localparam int unsigned I2S_TXFIFO_AE_DEF = 1;

  // Packs into the flag bits of the status register.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic ovf;
    logic unf;
  } i2s_fifo_status_t;

endpackage

// File: rtl/i2s_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, not reset.
module i2s_fifo_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              pclk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge pclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_tx_fifo.sv
// I2S transmit sample FIFO on the APB clock.
// Define I2S_TXFIFO_FWFT_EN for first-word fall-through reads; otherwise a
// pop returns the head word one cycle later on rdata with rvalid.
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W = I2S_DATA_W,
  parameter int unsigned DEPTH  = I2S_TXFIFO_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              clr,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  input  logic [AW:0]       af_thresh,
  input  logic [AW:0]       ae_thresh,
  output logic [AW:0]       level,
  output logic              ovf,
  output logic              unf,
  input  logic              flag_clr
);

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_acc, pop_acc;
  logic [DATA_W-1:0] mem_rdata;

  assign level        = level_q;
  assign full         = (level_q == LEVEL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);
  assign ovf          = ovf_q;
  assign unf          = unf_q;

  // A flush masks both strobes so it can neither move data nor raise flags.
  assign pop_acc  = ren && !empty && !clr;
  assign push_acc = wen && (!full || pop_acc) && !clr;

  i2s_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .pclk  (pclk),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_acc && !pop_acc) begin
        level_d = level_q + 1'b1;
      end else if (!push_acc && pop_acc) begin
        level_d = level_q - 1'b1;
      end
    end
    // Set has priority over flag_clr so a same-cycle error is never lost.
    ovf_d = (ovf_q && !flag_clr) || (wen && full && !pop_acc && !clr);
    unf_d = (unf_q && !flag_clr) || (ren && empty && !clr);
  end

  // Control state register.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef I2S_TXFIFO_FWFT_EN
  assign rdata  = mem_rdata;
  assign rvalid = !empty;
`else
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  // Registered read: capture the head word on an accepted pop.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= pop_acc;
      if (pop_acc) rdata_q <= mem_rdata;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Directed self-checking bench for i2s_tx_fifo (DEPTH 8, DATA_W 32).
module tb_i2s_tx_fifo;

  logic        pclk;
  logic        preset;
  logic        clr;
  logic        wen;
  logic [31:0] wdata;
  logic        ren;
  logic [31:0] rdata;
  logic        rvalid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  af_thresh;
  logic [3:0]  ae_thresh;
  logic [3:0]  level;
  logic        ovf;
  logic        unf;
  logic        flag_clr;

  int n_tests = 0;
  int n_fail  = 0;

  i2s_tx_fifo #(
    .DATA_W (32),
    .DEPTH  (8)
  ) dut (
    .pclk         (pclk),
    .preset       (preset),
    .clr          (clr),
    .wen          (wen),
    .wdata        (wdata),
    .ren          (ren),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .level        (level),
    .ovf          (ovf),
    .unf          (unf),
    .flag_clr     (flag_clr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wen   = 1'b1;
    wdata = d;
    tick();
    wen   = 1'b0;
  endtask

  // Pop and check the returned word, optionally pushing in the same cycle.
  task automatic pop_exp(input string tag, input logic [31:0] exp,
                         input logic wr, input logic [31:0] wd);
`ifdef I2S_TXFIFO_FWFT_EN
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp);
`endif
    wen   = wr;
    wdata = wd;
    ren   = 1'b1;
    tick();
    ren   = 1'b0;
    wen   = 1'b0;
`ifndef I2S_TXFIFO_FWFT_EN
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp);
`endif
  endtask

  initial begin
    preset    = 1'b0;
    clr       = 1'b0;
    wen       = 1'b0;
    wdata     = '0;
    ren       = 1'b0;
    flag_clr  = 1'b0;
    af_thresh = 4'd6;
    ae_thresh = 4'd1;

    // Reset state
    repeat (2) tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_unf", 32'(unf), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
`ifndef I2S_TXFIFO_FWFT_EN
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
`else
    check("rst_rvalid", 32'(rvalid), 32'd0);
`endif
    preset = 1'b1;
    tick();

    // Fill with A0..A7
    for (int i = 0; i < 8; i++) begin
      push(32'hA0 + 32'(i));
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end

    // Overflow drops the word and sets ovf
    push(32'hDEAD);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_level", 32'(level), 32'd8);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);

    // Drain in order; 0xDEAD must never appear
    for (int i = 0; i < 8; i++) begin
      pop_exp("drain_a", 32'hA0 + 32'(i), 1'b0, '0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    tick();
    check("idle_rvalid", 32'(rvalid), 32'd0);

    // Underflow with coincident flag_clr: set wins
    ren      = 1'b1;
    flag_clr = 1'b1;
    tick();
    ren      = 1'b0;
    flag_clr = 1'b0;
    check("unf_set", 32'(unf), 32'd1);
    check("unf_rvalid", 32'(rvalid), 32'd0);
`ifndef I2S_TXFIFO_FWFT_EN
    check("unf_rdata_hold", rdata, 32'hA7);
`endif

    // Push + pop on empty: push only, no bypass
    wen   = 1'b1;
    wdata = 32'h55;
    ren   = 1'b1;
    tick();
    wen   = 1'b0;
    ren   = 1'b0;
    check("emp_wr_level", 32'(level), 32'd1);
    check("emp_wr_unf", 32'(unf), 32'd1);
`ifndef I2S_TXFIFO_FWFT_EN
    check("emp_wr_rvalid", 32'(rvalid), 32'd0);
`endif
    pop_exp("emp_wr_pop", 32'h55, 1'b0, '0);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("unf_clr", 32'(unf), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(32'hB0 + 32'(i));
    pop_exp("full_rw", 32'hB0, 1'b1, 32'h99);
    check("full_rw_level", 32'(level), 32'd8);
    check("full_rw_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i < 8; i++) pop_exp("full_rw_drain", 32'hB0 + 32'(i), 1'b0, '0);
    pop_exp("full_rw_last", 32'h99, 1'b0, '0);
    check("full_rw_empty", 32'(empty), 32'd1);

    // Threshold edge cases
    af_thresh = 4'd0;
    #1;
    check("af_zero", 32'(almost_full), 32'd1);
    af_thresh = 4'd6;
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(i));
    check("ae_above", 32'(almost_empty), 32'd0);
    ae_thresh = 4'd8;
    #1;
    check("ae_depth", 32'(almost_empty), 32'd1);
    ae_thresh = 4'd1;

    // Interleaved push/pop at level 3 across pointer wrap
    for (int i = 0; i < 20; i++) begin
      pop_exp("wrap", 32'h100 + 32'(i), 1'b1, 32'h103 + 32'(i));
    end
    check("wrap_level", 32'(level), 32'd3);
    check("wrap_ovf", 32'(ovf), 32'd0);
    check("wrap_unf", 32'(unf), 32'd0);

    // Flush with write and read strobes asserted
    clr   = 1'b1;
    wen   = 1'b1;
    wdata = 32'hEE;
    ren   = 1'b1;
    tick();
    clr   = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    check("clr_level", 32'(level), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_unf", 32'(unf), 32'd0);
    check("clr_rvalid", 32'(rvalid), 32'd0);
    push(32'h77);
    check("post_clr_level", 32'(level), 32'd1);
    pop_exp("post_clr_pop", 32'h77, 1'b0, '0);

    // Asynchronous reset between edges, mid-burst
    for (int i = 0; i < 3; i++) push(32'hE0 + 32'(i));
    pop_exp("pre_rst", 32'hE0, 1'b1, 32'hE3);
    #2;
    preset = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full", 32'(full), 32'd0);
    check("arst_rvalid", 32'(rvalid), 32'd0);
`ifndef I2S_TXFIFO_FWFT_EN
    check("arst_rdata", rdata, 32'd0);
`endif
    #1;
    preset = 1'b1;
    tick();
    check("post_rst_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
Transmit-side sample FIFO for the I2S transceiver, clocked on the APB clock.
- Write side: fed by the register block's Tx data word and its one-cycle write strobe.
- Read side: drained by the I2S serializer's pop strobe.
- Status outputs drive the full/empty bits in the status register, plus almost-full/almost-empty, a fill level, and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 32, sample word width.
- DEPTH, 8, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), derived localparam; pointer width.

Ports:
- pclk  in  1  clock.
- preset  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush from the control register.
- wen  in  1  push strobe from the register block.
- wdata  in  DATA_W  push data.
- ren  in  1  pop strobe from the serializer.
- rdata  out  DATA_W  popped or head word.
- rvalid  out  1  rdata holds a valid popped word.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= af_thresh.
- almost_empty  out  1  level <= ae_thresh.
- af_thresh  in  AW+1  almost-full threshold.
- ae_thresh  in  AW+1  almost-empty threshold.
- level  out  AW+1  current occupancy.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.
- flag_clr  in  1  clears ovf and unf.

Behaviour:
- Reset (preset low, asynchronous): wr_ptr = 0, rd_ptr = 0, level = 0, rdata = 0, rvalid = 0, ovf = 0, unf = 0, so empty = 1 and full = 0. Storage array is not reset.
- Pointers are AW bits and wrap modulo DEPTH. Level is an AW+1-bit counter: +1 on an accepted push, -1 on an accepted pop, unchanged when both occur.
- Push is accepted if wen && (!full || pop accepted in the same cycle): mem[wr_ptr] <= wdata, wr_ptr + 1.
- Pop is accepted if ren && !empty: rd_ptr + 1.
- Standard mode: on an accepted pop, rdata <= mem[rd_ptr] and rvalid = 1 for one cycle (latency 1). Otherwise rvalid = 0 and rdata holds its value.
- Full with wen and ren together: both are accepted and level stays at DEPTH.
- Empty with wen and ren together: push is accepted, pop is an underflow, level becomes 1. There is no bypass.
- Overflow: wen && full && no accepted pop → word dropped, ovf <= 1.
- Underflow: ren && empty → unf <= 1, rdata unchanged, rvalid = 0.
- flag_clr clears ovf and unf. If a new error occurs in the same cycle, the set wins.
- clr: pointers and level go to 0 and rvalid to 0 on the next edge. Any coincident wen or ren is ignored, with no ovf/unf set. Sticky flags are not affected by clr.
- All status outputs (full, empty, almost_*, level) are derived combinationally from the registered level, so they are valid in the cycle after the update.
- Thresholds are compared unsigned. af_thresh = 0 forces almost_full = 1; ae_thresh >= DEPTH forces almost_empty = 1.

Optional Feature:
I2S_TXFIFO_FWFT_EN
- Defined (first-word fall-through): rdata continuously shows mem[rd_ptr], and rvalid = !empty. ren acknowledges and pops the head word, which becomes visible combinationally from the storage read after the pointer advances. Underflow and flag rules are unchanged.
- Undefined: standard registered-read mode as described in Behaviour.

Decomposition:
- Package i2s_pkg holds:
  - I2S_DATA_W localparam (32);
  - typedef i2s_fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, ovf, unf} used to pack into the status-register flag bits;
  - default threshold constants I2S_TXFIFO_AF_DEF = DEPTH-2 and AE_DEF = 1.
- One sub-module, i2s_fifo_mem: DEPTH×DATA_W array with synchronous write and asynchronous read port. The pointer/flag control stays in i2s_tx_fifo.

Test Plan:
- Reset, then push 0xA0..0xA7 (DEPTH 8) → full = 1 after the 8th push, level = 8, almost_full set at level 6 (af_thresh 6). Pop 8 → rdata sequence 0xA0..0xA7, each 1 cycle after ren, empty = 1 at end.
- Full FIFO, push 0xDEAD without pop → ovf = 1, level stays 8, later pops never return 0xDEAD. Pulse flag_clr → ovf = 0.
- Empty FIFO, ren alone → unf = 1, rvalid = 0. Then same-cycle wen (0x55) + ren on empty → level = 1, unf stays 1, next pop returns 0x55.
- Full FIFO, wen (0x99) + ren same cycle → level stays 8, oldest word popped, 0x99 is the last word out after draining.
- Wrap-around: 20 interleaved push/pop pairs at level 3 → data order preserved across pointer wrap, no ovf/unf. Mid-stream clr with wen asserted → level = 0, empty = 1, write dropped, ovf unchanged.
- preset asserted mid-burst asynchronously → outputs at reset values immediately. With I2S_TXFIFO_FWFT_EN defined, rdata equals the head word whenever rvalid = 1.
